// File: rtl/mac_ctrl_pkg.sv
// Shared state encoding, instruction codes and default timeout margin
// for the MAC array phase sequencer.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_EXEC,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int DEF_TIMEOUT_MARGIN = 16;

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Bus between the phase sequencer, the upstream input FIFO and the MAC array.
// master = sequencer side, slave = FIFO/array side.
interface mac_array_ctrl_if #(
    parameter int col = 8
);
    logic           src_empty;
    logic           src_rd;
    logic [1:0]     inst_w;
    logic           mode;
    logic           data_mode;
    logic [col-1:0] valid_in;

    modport master (
        input  src_empty,
        input  valid_in,
        output src_rd,
        output inst_w,
        output mode,
        output data_mode
    );

    modport slave (
        output src_empty,
        output valid_in,
        input  src_rd,
        input  inst_w,
        input  mode,
        input  data_mode
    );

endinterface

// File: rtl/mac_ctrl_phase_cnt.sv
// Loadable down-counter with decrement enable and zero flag; stops at zero.
module mac_ctrl_phase_cnt #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             dec,
    output logic [width-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Phase sequencer for the 2D MAC array: kernel load, skew flush, execute, drain.
// Optional drain timeout is enabled by defining MAC_CTRL_TIMEOUT_EN.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int row            = 8,
    parameter int col            = 8,
    parameter int cnt_bw         = 8,
    parameter int TIMEOUT_MARGIN = DEF_TIMEOUT_MARGIN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [cnt_bw-1:0] kernel_len,
    input  logic [cnt_bw-1:0] exec_len,
    input  logic              mode_cfg,
    input  logic              data_mode_cfg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [cnt_bw-1:0] out_cnt,
    mac_array_ctrl_if.master  bus
);

    localparam logic [cnt_bw-1:0] DRAIN_LIMIT = cnt_bw'(row + col + TIMEOUT_MARGIN);
    localparam logic [cnt_bw-1:0] CNT_ONE     = cnt_bw'(1);

    state_t            state, state_next;
    logic              start_acc;
    logic              rd;
    logic              valid_last;
    logic [1:0]        inst_q;
    logic              mode_q;
    logic              dm_q;
    logic [cnt_bw-1:0] exec_len_q;
    logic [cnt_bw-1:0] gap_len;
    logic [cnt_bw-1:0] load_left, exec_left, phase_left;
    logic              load_zero, exec_zero, phase_zero;
    logic              phase_load;
    logic [cnt_bw-1:0] phase_val;
    logic              phase_dec;
    logic              set_err;

    assign start_acc  = (state == ST_IDLE) && start;
    assign rd         = ((state == ST_LOAD) || (state == ST_EXEC)) && !bus.src_empty;
    assign valid_last = bus.valid_in[col-1];
    assign gap_len    = dm_q ? CNT_ONE : cnt_bw'(row);

    assign bus.src_rd    = rd;
    assign bus.inst_w    = inst_q;
    assign bus.mode      = mode_q;
    assign bus.data_mode = dm_q;
    assign busy          = (state != ST_IDLE);

    mac_ctrl_phase_cnt #(.width(cnt_bw)) u_load_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_acc),
        .load_val (kernel_len),
        .dec      ((state == ST_LOAD) && rd),
        .count    (load_left),
        .zero     (load_zero)
    );

    mac_ctrl_phase_cnt #(.width(cnt_bw)) u_exec_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_acc),
        .load_val (exec_len),
        .dec      ((state == ST_EXEC) && rd),
        .count    (exec_left),
        .zero     (exec_zero)
    );

    // Shared between the skew-flush length and the drain watchdog.
    mac_ctrl_phase_cnt #(.width(cnt_bw)) u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .load_val (phase_val),
        .dec      (phase_dec),
        .count    (phase_left),
        .zero     (phase_zero)
    );

`ifdef MAC_CTRL_TIMEOUT_EN
    assign phase_dec = (state == ST_GAP) || (state == ST_DRAIN);
`else
    assign phase_dec = (state == ST_GAP);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_load = 1'b0;
        phase_val  = '0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (exec_len == '0) begin
                        state_next = ST_DONE;
                    end else if (kernel_len == '0) begin
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (rd && (load_left == CNT_ONE)) begin
                    state_next = ST_GAP;
                    phase_load = 1'b1;
                    phase_val  = gap_len;
                end
            end
            ST_GAP: begin
                if (phase_left <= CNT_ONE) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (rd && (exec_left == CNT_ONE)) begin
                    state_next = ST_DRAIN;
                    phase_load = 1'b1;
                    phase_val  = DRAIN_LIMIT;
                end
            end
            ST_DRAIN: begin
                if (out_cnt == exec_len_q) begin
                    state_next = ST_DONE;
                end
`ifdef MAC_CTRL_TIMEOUT_EN
                else if (phase_zero) begin
                    state_next = ST_DONE;
                    set_err    = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction is registered so it lines up with the FIFO's 1-cycle read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_q <= INST_NOP;
            done   <= 1'b0;
        end else begin
            inst_q <= {(state == ST_EXEC) && rd, (state == ST_LOAD) && rd};
            done   <= (state == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= 1'b0;
            dm_q       <= 1'b0;
            exec_len_q <= '0;
            out_cnt    <= '0;
        end else if (start_acc) begin
            mode_q     <= mode_cfg;
            dm_q       <= data_mode_cfg;
            exec_len_q <= exec_len;
            out_cnt    <= '0;
        end else if (((state == ST_EXEC) || (state == ST_DRAIN)) && valid_last && (out_cnt != '1)) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

`ifdef MAC_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start_acc) begin
            err <= 1'b0;
        end else if (set_err) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    logic unused_sink;
    assign unused_sink = ^{bus.valid_in, load_zero, exec_zero, phase_zero, set_err, DRAIN_LIMIT};

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Phase sequencer for the 2D MAC array. On `start` it pulls kernel words from the upstream input FIFO and issues kernel-load instructions, then flushes the row skew, then pulls activations and issues execute instructions. It then waits for the array's last column to return every result before pulsing `done`. It drives the array's `inst_w`, `mode` and `data_mode` inputs and the FIFO read strobe.

## Interface
- `row`, 8: array rows; sets the skew-flush length.
- `col`, 8: array columns; width of `valid_in`.
- `cnt_bw`, 8: width of the length and count fields.
- `TIMEOUT_MARGIN`, 16: extra drain cycles allowed before error (timeout build only).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request; accepted only in IDLE.
- `kernel_len` in cnt_bw: number of kernel words to load; sampled at start.
- `exec_len` in cnt_bw: number of activation vectors; sampled at start.
- `mode_cfg` in 1: array mode; latched at start.
- `data_mode_cfg` in 1: 1 = broadcast instructions, 0 = row-skewed; latched at start.
- `src_empty` in 1: upstream FIFO empty.
- `src_rd` out 1: FIFO read strobe; the FIFO has a 1-cycle read latency.
- `inst_w` out 2: array instruction; bit1 = execute, bit0 = kernel load.
- `mode` out 1: latched `mode_cfg`.
- `data_mode` out 1: latched `data_mode_cfg`.
- `valid_in` in col: array `valid` bus.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: drain timeout, sticky until the next start.
- `out_cnt` out cnt_bw: results counted in the current job.

## Operation
States:
- IDLE: waits for start; `start` with `exec_len`=0 goes to DONE.
- LOAD: runs while `load_left`>0. `src_rd`=!`src_empty`; each read decrements `load_left`. When it reaches 0, go to GAP. `kernel_len`=0 skips LOAD and GAP (preloaded weights reused) and goes straight to EXEC.
- GAP: issues `inst_w`=00 for `data_mode` ? 1 : `row` cycles, so the last load instruction clears the bottom row. Then go to EXEC.
- EXEC: same as LOAD, using `exec_left`; when it reaches 0, go to DRAIN.
- DRAIN: waits until `out_cnt`==`exec_len`, then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.

Rules:
- Instruction: `inst_w` is registered and equals {EXEC&&`src_rd`, LOAD&&`src_rd`} from the previous cycle, so it aligns with the FIFO data. An empty FIFO inserts a 00 bubble; the bubble travels down the skew with the data, so no stall logic is needed downstream.
- `src_rd` is combinational and is never high when `src_empty`=1 or outside LOAD/EXEC.
- `out_cnt` clears on accepted start. It increments on `valid_in[col-1]` during EXEC and DRAIN only, and saturates at all-ones. Valid pulses in IDLE are ignored.
- `start` while busy is ignored; lengths and config do not change mid-job.
- Reset values: state IDLE; `inst_w`=00; `src_rd`, `busy`, `done` and `err` all 0; `mode`, `data_mode` and `out_cnt` all 0.
- Reset mid-job aborts immediately. No `done` pulse is produced, and `inst_w` returns to 00 asynchronously.

## Timing
- Start accepted at cycle t: `busy`=1 from t+1. The first `src_rd` can assert at t+1; the matching `inst_w`=01 appears at t+2.
- LOAD with no bubbles lasts exactly `kernel_len` cycles. GAP lasts 1 or `row` cycles. EXEC lasts `exec_len` cycles plus one cycle per empty bubble.
- The DRAIN→DONE transition is taken the cycle after the final counted valid.
- `done` rises one cycle after that and lasts 1 cycle; IDLE follows.
- A valid pulse in the same cycle as the last EXEC read is counted.

## Configuration
- `MAC_CTRL_TIMEOUT_EN` defined: a drain-cycle counter runs in DRAIN. If it exceeds `row`+`col`+`TIMEOUT_MARGIN`, `err`=1 and the FSM goes to DONE.
- Not defined: no timeout counter, `err` tied to 0, and DRAIN waits indefinitely.

## Structure
- `mac_ctrl_pkg` holds:
  - the state enum;
  - `INST_NOP`=2'b00, `INST_LOAD`=2'b01, `INST_EXEC`=2'b10;
  - the default `TIMEOUT_MARGIN`.
- One sub-module, `mac_ctrl_phase_cnt`: a loadable down-counter with a decrement enable and a zero flag. It is instantiated for `load_left`, `exec_left` and the GAP/timeout count.

## Test plan
- Basic job: `kernel_len`=8, `exec_len`=4, `data_mode`=0, FIFO never empty, 4 valids returned → 8 cycles of `inst_w`=01, 8 cycles of 00, 4 cycles of 10, `out_cnt`=4, one `done` pulse, `err`=0.
- Bubbles: `src_empty` high every 3rd cycle during EXEC, `exec_len`=6 → exactly 6 cycles with `inst_w`=10, 00 in the bubble cycles, `src_rd` never high while empty.
- Weight reuse: `kernel_len`=0, `exec_len`=3 → no 01 instructions and no GAP; EXEC starts at t+1.
- `exec_len`=0 → `done` at t+2, no `src_rd`.
- Abort: reset asserted in the middle of EXEC → `inst_w`=00, `busy`=0 immediately, no `done`. A following job runs normally.
- Timeout (`MAC_CTRL_TIMEOUT_EN`): `exec_len`=4 with only 3 valids returned → `err`=1 and `done` after 8+8+16 drain cycles.
